vcore_disp_sched: RTL and testbench
===================================

Name: vcore_disp_sched

Overview:
- Issue scheduler between the decode/dispatch pipeline register and the two vector execution back-ends: the arithmetic unit (VALU) and the load/store unit (VLSU).
- Holds a per-register busy scoreboard and one credit counter per back-end, and gates each dispatched instruction until it is hazard-free and has a credit.
- Also implements a fence/drain sequence for CSR or vlen changes.
- Carries no payload. The parent routes the dispatch record alongside the handshake this block generates.

Parameters:
- VRF_ID_W, 5, width of vector register id; the scoreboard has 2**VRF_ID_W entries.
- ALU_CREDITS, 4, maximum in-flight VALU instructions.
- LSU_CREDITS, 2, maximum in-flight VLSU instructions.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- disp_valid_in  in  1  dispatch record valid from the pipeline register
- disp_ready_out  out  1  record consumed this cycle
- disp_is_ls  in  1  1 = load/store class (VFLD/VFSLD/VFST), 0 = arithmetic
- disp_vsrc0_vld  in  1  vector source 0 is valid
- disp_vsrc0_id  in  VRF_ID_W  vector source 0 register id
- disp_vsrc1_vld  in  1  vector source 1 is valid
- disp_vsrc1_id  in  VRF_ID_W  vector source 1 register id
- disp_vdst_vld  in  1  vector destination is valid
- disp_vdst_id  in  VRF_ID_W  vector destination register id
- alu_issue_valid  out  1  issue to VALU
- alu_issue_ready  in  1  VALU accepts
- lsu_issue_valid  out  1  issue to VLSU
- lsu_issue_ready  in  1  VLSU accepts
- alu_done  in  1  VALU retired one instruction (returns one credit)
- lsu_done  in  1  VLSU retired one instruction (returns one credit)
- wb_vld  in  1  vector writeback valid
- wb_id  in  VRF_ID_W  writeback register id (clears its scoreboard bit)
- fence_req  in  1  level request to drain
- fence_ack  out  1  one-cycle pulse: machine is empty
- idle  out  1  scoreboard empty and all credits home
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst sampled high at a clk edge): scoreboard all 0; credits = ALU_CREDITS / LSU_CREDITS; FSM = RUN; err = 0.
  - While rst is high, disp_ready_out, alu_issue_valid, lsu_issue_valid and fence_ack are forced 0.
  - Reset mid-operation discards all in-flight tracking, with no ack.
- Hazard definition: hz = (vsrc0_vld & sb[vsrc0_id]) | (vsrc1_vld & sb[vsrc1_id]) | (vdst_vld & sb[vdst_id]). This covers RAW and WAW.
- Credit check: cr_ok = disp_is_ls ? lsu_cnt != 0 : alu_cnt != 0.
- Issue condition: go = disp_valid_in & state==RUN & ~hz & cr_ok.
- Issue outputs are combinational, zero-latency:
  - alu_issue_valid = go & ~disp_is_ls
  - lsu_issue_valid = go & disp_is_ls
  - disp_ready_out = the selected valid AND its ready
- Valid is never asserted for a hazarded, credit-less or fenced record. Once asserted, valid may drop only if disp_valid_in drops.
- On a completed handshake:
  - if vdst_vld, sb[vdst_id] <= 1;
  - the selected credit counter decrements.
- Writeback: wb_vld clears sb[wb_id] at the next edge.
  - There is no same-cycle bypass: a record stalled on wb_id issues no earlier than the following cycle.
  - wb_vld to an id whose bit is already 0 sets err.
- Set on issue and clear on writeback for different ids in the same cycle both take effect.
- Credit counter rules:
  - done and issue in the same cycle: count unchanged.
  - done while the count is at its maximum: ignored, and err is set.
  - Counter widths are $clog2(max+1).
- FSM states:
  - RUN: issues normally. fence_req=1 moves to DRAIN. fence_req takes priority over a pending issue in the same cycle, so no issue occurs in that cycle.
  - DRAIN: no issue. When idle=1, move to ACK.
  - ACK: fence_ack=1 for exactly one cycle, then return to RUN. The requester must drop fence_req in the ACK cycle. If fence_req is still high in RUN, a new DRAIN starts.
- idle = (sb==0) & alu_cnt==ALU_CREDITS & lsu_cnt==LSU_CREDITS. It is combinational from registers.
- err is sticky until reset.

Test Plan:
- Basic issue: reset, then arithmetic record with vsrc0=3, vdst=5 and alu_issue_ready=1 -> handshake in the same cycle, sb[5]=1, alu_cnt 4->3, idle=0.
- RAW hazard: next record reads v5 -> stalls with both issue valids 0. Pulse wb_vld with wb_id=5 at cycle N -> issue at cycle N+1. alu_done then returns the credit.
- Credit exhaustion: issue 2 stores (vdst_vld=0) with no lsu_done -> third load stalls with lsu_cnt=0. One lsu_done -> the load issues the next cycle. Sb bits are never set for the stores.
- Simultaneous events: alu_done plus an ALU issue in the same cycle -> alu_cnt unchanged. wb of v7 plus issue with vdst=9 -> sb[7]=0, sb[9]=1.
- Fence: fence_req with 1 VALU instruction in flight -> DRAIN, a pending record is held. After wb and alu_done -> fence_ack pulses for 1 cycle, then RUN and the record issues.
- Errors and reset: wb to a clear id -> err=1 and stays set. Spurious alu_done at 4 credits -> counter stays at 4. rst asserted during DRAIN -> RUN next cycle, err=0, idle=1, no fence_ack.

Source files
------------

// File: rtl/vcore_disp_sched_if.sv
// ---------------------------------------------------------------------------
// vcore_disp_sched_if
//
// Handshake bundle between the dispatch pipeline register, the issue
// scheduler and the two vector back-ends (VALU, VLSU).
//
// Signals:
//   disp_valid_in   dispatch record valid
//   disp_ready_out  record consumed this cycle
//   disp_is_ls      1 = load/store class, 0 = arithmetic
//   disp_vsrc0_*    vector source 0 valid / id
//   disp_vsrc1_*    vector source 1 valid / id
//   disp_vdst_*     vector destination valid / id
//   alu_issue_*     issue handshake towards the VALU
//   lsu_issue_*     issue handshake towards the VLSU
//
// Modports:
//   master  the surroundings: pipeline register plus back-end ready lines
//   slave   the scheduler itself
// ---------------------------------------------------------------------------
interface vcore_disp_sched_if #(
    parameter int VRF_ID_W = 5
);
    logic                disp_valid_in;
    logic                disp_ready_out;
    logic                disp_is_ls;
    logic                disp_vsrc0_vld;
    logic [VRF_ID_W-1:0] disp_vsrc0_id;
    logic                disp_vsrc1_vld;
    logic [VRF_ID_W-1:0] disp_vsrc1_id;
    logic                disp_vdst_vld;
    logic [VRF_ID_W-1:0] disp_vdst_id;
    logic                alu_issue_valid;
    logic                alu_issue_ready;
    logic                lsu_issue_valid;
    logic                lsu_issue_ready;

    modport master (
        output disp_valid_in, disp_is_ls,
        output disp_vsrc0_vld, disp_vsrc0_id,
        output disp_vsrc1_vld, disp_vsrc1_id,
        output disp_vdst_vld, disp_vdst_id,
        output alu_issue_ready, lsu_issue_ready,
        input  disp_ready_out, alu_issue_valid, lsu_issue_valid
    );

    modport slave (
        input  disp_valid_in, disp_is_ls,
        input  disp_vsrc0_vld, disp_vsrc0_id,
        input  disp_vsrc1_vld, disp_vsrc1_id,
        input  disp_vdst_vld, disp_vdst_id,
        input  alu_issue_ready, lsu_issue_ready,
        output disp_ready_out, alu_issue_valid, lsu_issue_valid
    );
endinterface

// File: rtl/vcore_disp_sched.sv
// ---------------------------------------------------------------------------
// vcore_disp_sched
//
// Issue scheduler between the dispatch pipeline register and the VALU/VLSU
// back-ends. Tracks pending vector register writes in a busy scoreboard,
// keeps one credit counter per back-end, and only lets a record through when
// it is hazard-free and its back-end has a credit. A fence request drains
// the machine and answers with a one-cycle fence_ack.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   disp         handshake bundle (slave side), see vcore_disp_sched_if
//   alu_done     VALU retired one instruction (credit return)
//   lsu_done     VLSU retired one instruction (credit return)
//   wb_vld/wb_id vector writeback, clears the scoreboard bit of wb_id
//   fence_req    level request to drain
//   fence_ack    one-cycle pulse once the machine is empty
//   idle         scoreboard empty and all credits home
//   err          sticky protocol error
// ---------------------------------------------------------------------------
module vcore_disp_sched #(
    parameter int VRF_ID_W    = 5,
    parameter int ALU_CREDITS = 4,
    parameter int LSU_CREDITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    vcore_disp_sched_if.slave   disp,
    input  logic                alu_done,
    input  logic                lsu_done,
    input  logic                wb_vld,
    input  logic [VRF_ID_W-1:0] wb_id,
    input  logic                fence_req,
    output logic                fence_ack,
    output logic                idle,
    output logic                err
);

    localparam int NUM_REGS = 1 << VRF_ID_W;
    localparam int ALU_CW   = $clog2(ALU_CREDITS + 1);
    localparam int LSU_CW   = $clog2(LSU_CREDITS + 1);
    localparam logic [ALU_CW-1:0] ALU_MAX = ALU_CW'(ALU_CREDITS);
    localparam logic [LSU_CW-1:0] LSU_MAX = LSU_CW'(LSU_CREDITS);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] sb, sb_d;
    logic [ALU_CW-1:0]   alu_cnt, alu_cnt_d;
    logic [LSU_CW-1:0]   lsu_cnt, lsu_cnt_d;
    logic                err_q, err_d;

    logic hz, cr_ok, go;
    logic alu_fire, lsu_fire, any_fire;
    logic alu_inc, lsu_inc;
    logic fence_ack_c;

    // Hazard and credit gating. The scoreboard is read as registered, so a
    // writeback only unblocks a record on the cycle after it is seen. A
    // fence request in RUN wins over a pending issue in the same cycle, and
    // reset holds every issue output low.
    always_comb begin
        hz = (disp.disp_vsrc0_vld & sb[disp.disp_vsrc0_id])
           | (disp.disp_vsrc1_vld & sb[disp.disp_vsrc1_id])
           | (disp.disp_vdst_vld  & sb[disp.disp_vdst_id]);
        cr_ok = disp.disp_is_ls ? (lsu_cnt != '0) : (alu_cnt != '0);
        go = disp.disp_valid_in & (state_q == RUN) & ~fence_req & ~rst
           & ~hz & cr_ok;
    end

    assign disp.alu_issue_valid = go & ~disp.disp_is_ls;
    assign disp.lsu_issue_valid = go &  disp.disp_is_ls;
    assign alu_fire             = disp.alu_issue_valid & disp.alu_issue_ready;
    assign lsu_fire             = disp.lsu_issue_valid & disp.lsu_issue_ready;
    assign any_fire             = alu_fire | lsu_fire;
    assign disp.disp_ready_out  = any_fire;

    assign idle = (sb == '0) & (alu_cnt == ALU_MAX) & (lsu_cnt == LSU_MAX);
    assign err  = err_q;

    // Scoreboard and credit next-state. The writeback clear is applied
    // before the issue set; the two can only meet on the same id when the
    // writeback was spurious, in which case the new write must stay
    // tracked. A credit return while the counter is already full has no
    // instruction to belong to, so it is dropped and flagged instead of
    // wrapping the counter.
    always_comb begin
        sb_d = sb;
        if (wb_vld) begin
            sb_d[wb_id] = 1'b0;
        end
        if (any_fire && disp.disp_vdst_vld) begin
            sb_d[disp.disp_vdst_id] = 1'b1;
        end

        alu_inc   = alu_done & (alu_cnt != ALU_MAX);
        lsu_inc   = lsu_done & (lsu_cnt != LSU_MAX);
        alu_cnt_d = alu_cnt + ALU_CW'(alu_inc) - ALU_CW'(alu_fire);
        lsu_cnt_d = lsu_cnt + LSU_CW'(lsu_inc) - LSU_CW'(lsu_fire);

        err_d = err_q
              | (wb_vld & ~sb[wb_id])
              | (alu_done & (alu_cnt == ALU_MAX))
              | (lsu_done & (lsu_cnt == LSU_MAX));
    end

    // Fence sequencing: RUN -> DRAIN on request, DRAIN waits for the
    // machine to empty, ACK pulses fence_ack once and returns to RUN. A
    // request still held in RUN simply starts another drain.
    always_comb begin
        state_d     = state_q;
        fence_ack_c = 1'b0;
        unique case (state_q)
            RUN: begin
                if (fence_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (idle) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                fence_ack_c = 1'b1;
                state_d     = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign fence_ack = fence_ack_c & ~rst;

    // State register. Reset drops all in-flight tracking outright and
    // returns every credit home without passing through ACK.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            sb      <= '0;
            alu_cnt <= ALU_MAX;
            lsu_cnt <= LSU_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sb      <= sb_d;
            alu_cnt <= alu_cnt_d;
            lsu_cnt <= lsu_cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_vcore_disp_sched.sv
// ---------------------------------------------------------------------------
// tb_vcore_disp_sched
//
// Directed bench for the issue scheduler. The stimulus process announces
// each issue it expects (back-end and cycle) into a queue; a monitor pops
// that queue whenever a handshake completes. Status outputs and internal
// counters are compared against hand-computed values at negative edges.
// ---------------------------------------------------------------------------
module tb_vcore_disp_sched;

    localparam int VRF_ID_W = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                alu_done;
    logic                lsu_done;
    logic                wb_vld;
    logic [VRF_ID_W-1:0] wb_id;
    logic                fence_req;
    logic                fence_ack;
    logic                idle;
    logic                err;

    vcore_disp_sched_if #(.VRF_ID_W(VRF_ID_W)) bus ();

    vcore_disp_sched #(
        .VRF_ID_W   (VRF_ID_W),
        .ALU_CREDITS(4),
        .LSU_CREDITS(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .disp     (bus.slave),
        .alu_done (alu_done),
        .lsu_done (lsu_done),
        .wb_vld   (wb_vld),
        .wb_id    (wb_id),
        .fence_req(fence_req),
        .fence_ack(fence_ack),
        .idle     (idle),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Cycle counter; the interval after posedge k carries the value k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_ls;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic is_ls,
                                 input logic s0v, input logic [VRF_ID_W-1:0] s0,
                                 input logic s1v, input logic [VRF_ID_W-1:0] s1,
                                 input logic dv,  input logic [VRF_ID_W-1:0] d);
        bus.disp_valid_in  = valid;
        bus.disp_is_ls     = is_ls;
        bus.disp_vsrc0_vld = s0v;
        bus.disp_vsrc0_id  = s0;
        bus.disp_vsrc1_vld = s1v;
        bus.disp_vsrc1_id  = s1;
        bus.disp_vdst_vld  = dv;
        bus.disp_vdst_id   = d;
    endtask

    task automatic expectIssue(input bit is_ls, input int offset);
        expq.push_back('{is_ls: is_ls, cyc: cyc + offset});
    endtask

    // Monitor: every completed handshake must match the oldest announced
    // issue in back-end and cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && ((bus.alu_issue_valid && bus.alu_issue_ready) ||
                     (bus.lsu_issue_valid && bus.lsu_issue_ready))) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_issue: got issue at cycle %0d, expected none", cyc);
            end else begin
                e = expq.pop_front();
                checkOutput("issue_is_ls", {31'b0, bus.lsu_issue_valid}, {31'b0, e.is_ls});
                checkOutput("issue_cycle", cyc, e.cyc);
                checkOutput("disp_ready", {31'b0, bus.disp_ready_out}, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        alu_done = 1'b0;
        lsu_done = 1'b0;
        wb_vld = 1'b0;
        wb_id = '0;
        fence_req = 1'b0;
        bus.alu_issue_ready = 1'b1;
        bus.lsu_issue_ready = 1'b1;
        applyStimulus(1, 0, 1, 5'd3, 0, 5'd0, 1, 5'd5);

        // Reset: outputs held low even with a valid record presented
        tick();
        tick();
        @(negedge clk);
        checkOutput("rst_alu_valid", {31'b0, bus.alu_issue_valid}, 32'd0);
        checkOutput("rst_disp_ready", {31'b0, bus.disp_ready_out}, 32'd0);
        checkOutput("rst_idle", {31'b0, idle}, 32'd1);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_alu_cnt", {29'b0, dut.alu_cnt}, 32'd4);

        // Basic issue: vsrc0=3, vdst=5
        tick();
        rst = 1'b0;
        expectIssue(0, 0);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        @(negedge clk);
        checkOutput("basic_sb5", {31'b0, dut.sb[5]}, 32'd1);
        checkOutput("basic_alu_cnt", {29'b0, dut.alu_cnt}, 32'd3);
        checkOutput("basic_idle", {31'b0, idle}, 32'd0);

        // RAW hazard on v5, released by writeback one cycle later
        tick();
        applyStimulus(1, 0, 1, 5'd5, 0, 5'd0, 1, 5'd6);
        @(negedge clk);
        checkOutput("raw_alu_valid", {31'b0, bus.alu_issue_valid}, 32'd0);
        checkOutput("raw_lsu_valid", {31'b0, bus.lsu_issue_valid}, 32'd0);
        tick();
        wb_vld = 1'b1;
        wb_id = 5'd5;
        expectIssue(0, 1);
        @(negedge clk);
        checkOutput("raw_no_bypass", {31'b0, bus.alu_issue_valid}, 32'd0);
        tick();
        wb_vld = 1'b0;
        @(negedge clk);
        checkOutput("raw_sb5_clear", {31'b0, dut.sb[5]}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        alu_done = 1'b1;
        @(negedge clk);
        checkOutput("raw_alu_cnt_out", {29'b0, dut.alu_cnt}, 32'd2);
        tick();
        alu_done = 1'b0;
        @(negedge clk);
        checkOutput("raw_alu_cnt_back", {29'b0, dut.alu_cnt}, 32'd3);
        checkOutput("raw_sb", dut.sb, 32'h0000_0040);

        // Credit exhaustion on the VLSU: two stores, then a stalled load
        tick();
        applyStimulus(1, 1, 1, 5'd1, 0, 5'd0, 0, 5'd0);
        expectIssue(1, 0);
        tick();
        expectIssue(1, 0);
        tick();
        applyStimulus(1, 1, 1, 5'd1, 0, 5'd0, 1, 5'd10);
        @(negedge clk);
        checkOutput("cred_lsu_valid", {31'b0, bus.lsu_issue_valid}, 32'd0);
        checkOutput("cred_lsu_cnt", {30'b0, dut.lsu_cnt}, 32'd0);
        checkOutput("cred_sb_stores", dut.sb, 32'h0000_0040);
        tick();
        lsu_done = 1'b1;
        expectIssue(1, 1);
        @(negedge clk);
        checkOutput("cred_still_stalled", {31'b0, bus.lsu_issue_valid}, 32'd0);
        tick();
        lsu_done = 1'b0;
        @(negedge clk);
        checkOutput("cred_lsu_cnt_one", {30'b0, dut.lsu_cnt}, 32'd1);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        lsu_done = 1'b1;
        wb_vld = 1'b1;
        wb_id = 5'd10;
        @(negedge clk);
        checkOutput("cred_lsu_cnt_zero", {30'b0, dut.lsu_cnt}, 32'd0);
        checkOutput("cred_sb_load", dut.sb, 32'h0000_0440);
        tick();
        wb_vld = 1'b0;
        tick();
        lsu_done = 1'b0;
        @(negedge clk);
        checkOutput("cred_lsu_cnt_home", {30'b0, dut.lsu_cnt}, 32'd2);
        checkOutput("cred_sb_after", dut.sb, 32'h0000_0040);

        // Simultaneous done+issue, and writeback+set on different ids
        tick();
        applyStimulus(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7);
        expectIssue(0, 0);
        tick();
        applyStimulus(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd9);
        expectIssue(0, 0);
        wb_vld = 1'b1;
        wb_id = 5'd7;
        alu_done = 1'b1;
        @(negedge clk);
        checkOutput("simul_alu_cnt_before", {29'b0, dut.alu_cnt}, 32'd2);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        wb_id = 5'd6;
        @(negedge clk);
        checkOutput("simul_alu_cnt_same", {29'b0, dut.alu_cnt}, 32'd2);
        checkOutput("simul_sb7", {31'b0, dut.sb[7]}, 32'd0);
        checkOutput("simul_sb9", {31'b0, dut.sb[9]}, 32'd1);
        tick();
        wb_id = 5'd9;
        tick();
        wb_vld = 1'b0;
        alu_done = 1'b0;
        @(negedge clk);
        checkOutput("simul_idle", {31'b0, idle}, 32'd1);
        checkOutput("simul_alu_cnt_home", {29'b0, dut.alu_cnt}, 32'd4);
        checkOutput("simul_err", {31'b0, err}, 32'd0);

        // Fence with one VALU instruction in flight and a record held back
        tick();
        applyStimulus(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd12);
        expectIssue(0, 0);
        tick();
        applyStimulus(1, 0, 1, 5'd2, 0, 5'd0, 1, 5'd13);
        fence_req = 1'b1;
        expectIssue(0, 4);
        @(negedge clk);
        checkOutput("fence_priority", {31'b0, bus.alu_issue_valid}, 32'd0);
        checkOutput("fence_priority_rdy", {31'b0, bus.disp_ready_out}, 32'd0);
        tick();
        wb_vld = 1'b1;
        wb_id = 5'd12;
        alu_done = 1'b1;
        @(negedge clk);
        checkOutput("drain_hold", {31'b0, bus.alu_issue_valid}, 32'd0);
        checkOutput("drain_no_ack", {31'b0, fence_ack}, 32'd0);
        checkOutput("drain_busy", {31'b0, idle}, 32'd0);
        tick();
        wb_vld = 1'b0;
        alu_done = 1'b0;
        @(negedge clk);
        checkOutput("drain_idle", {31'b0, idle}, 32'd1);
        checkOutput("drain_ack_early", {31'b0, fence_ack}, 32'd0);
        checkOutput("drain_hold2", {31'b0, bus.alu_issue_valid}, 32'd0);
        tick();
        fence_req = 1'b0;
        @(negedge clk);
        checkOutput("fence_ack_pulse", {31'b0, fence_ack}, 32'd1);
        checkOutput("ack_hold", {31'b0, bus.alu_issue_valid}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("fence_ack_single", {31'b0, fence_ack}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        wb_vld = 1'b1;
        wb_id = 5'd13;
        alu_done = 1'b1;
        tick();
        wb_vld = 1'b0;
        alu_done = 1'b0;
        @(negedge clk);
        checkOutput("fence_idle_after", {31'b0, idle}, 32'd1);
        checkOutput("fence_err", {31'b0, err}, 32'd0);

        // Errors: writeback to a clear id, spurious credit return
        tick();
        wb_vld = 1'b1;
        wb_id = 5'd20;
        tick();
        wb_vld = 1'b0;
        alu_done = 1'b1;
        @(negedge clk);
        checkOutput("err_wb_clear", {31'b0, err}, 32'd1);
        tick();
        alu_done = 1'b0;
        applyStimulus(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd15);
        expectIssue(0, 0);
        @(negedge clk);
        checkOutput("err_spurious_cnt", {29'b0, dut.alu_cnt}, 32'd4);
        checkOutput("err_sticky", {31'b0, err}, 32'd1);

        // Reset in the middle of a drain
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        fence_req = 1'b1;
        tick();
        applyStimulus(1, 0, 0, 5'd0, 0, 5'd0, 1, 5'd16);
        @(negedge clk);
        checkOutput("rdrain_hold", {31'b0, bus.alu_issue_valid}, 32'd0);
        checkOutput("rdrain_busy", {31'b0, idle}, 32'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rdrain_rst_ack", {31'b0, fence_ack}, 32'd0);
        tick();
        rst = 1'b0;
        fence_req = 1'b0;
        expectIssue(0, 0);
        @(negedge clk);
        checkOutput("rdrain_err", {31'b0, err}, 32'd0);
        checkOutput("rdrain_idle", {31'b0, idle}, 32'd1);
        checkOutput("rdrain_no_ack", {31'b0, fence_ack}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
        wb_vld = 1'b1;
        wb_id = 5'd16;
        alu_done = 1'b1;
        tick();
        wb_vld = 1'b0;
        alu_done = 1'b0;
        @(negedge clk);
        checkOutput("final_idle", {31'b0, idle}, 32'd1);
        checkOutput("final_err", {31'b0, err}, 32'd0);

        tick();
        tick();
        checkOutput("pending_issues", expq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
